// File: rtl/keccak_pkg.sv
// Shared Keccak output-stage definitions: lane width, rate word counts and
// the squeeze buffer state encoding.
package keccak_pkg;

   localparam int LANE_W         = 64;
   localparam int STATE_W        = 1600;
   localparam int RATE_WORDS_128 = 21;
   localparam int RATE_WORDS_256 = 17;
   localparam int BUF_W          = LANE_W * RATE_WORDS_128;

   typedef enum logic [1:0] {
      SQ_IDLE,
      SQ_WAIT_PERM,
      SQ_DRAIN,
      SQ_DONE
   } sq_state_t;

   // Index of the final word of a block for the selected rate.
   function automatic logic [4:0] last_idx(input logic mode);
      return mode ? 5'(RATE_WORDS_256 - 1) : 5'(RATE_WORDS_128 - 1);
   endfunction

endpackage

// File: rtl/squeeze_word_sel.sv
// Combinational 21:1 lane mux selecting one 64-bit word of the rate buffer.
module squeeze_word_sel
   import keccak_pkg::*;
(
   input  logic [BUF_W-1:0]  i_buf,
   input  logic [4:0]        i_idx,
   output logic [LANE_W-1:0] o_word
);

   always_comb begin
      o_word = '0;
      for (int k = 0; k < RATE_WORDS_128; k++) begin
         if (i_idx == 5'(k)) begin
            o_word = i_buf[LANE_W*k +: LANE_W];
         end
      end
   end

endmodule

// File: rtl/squeeze_buffer.sv
// Captures the rate part of each permuted Keccak state and pops it out as
// 64-bit words; optional double buffering under SQUEEZE_PREFETCH_EN.
module squeeze_buffer
   import keccak_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic               start_calc,
   input  logic [STATE_W-1:0] f_out,
   input  logic               f_out_ready,
   output logic               squeeze,
   input  logic               gimme,
   input  logic               stop,
   output logic [LANE_W-1:0]  out,
   output logic               out_ready,
   output logic               out_buf_empty
);

   sq_state_t         r_state, w_state_nxt;
   logic [4:0]        r_idx, w_idx_nxt;
   logic              r_mode, w_mode_nxt;
   logic              r_out_ready, w_ready_nxt;
   logic              r_squeeze, w_squeeze_nxt;
   logic [LANE_W-1:0] r_out;
   logic [BUF_W-1:0]  r_buf, w_buf_nxt, w_sel_buf;
   logic              w_buf_load;
   logic              w_out_load;
   logic [LANE_W-1:0] w_word;
   logic              w_last;
   logic              w_unused;

`ifdef SQUEEZE_PREFETCH_EN
   logic [BUF_W-1:0]  r_shadow;
   logic              r_shadow_vld, w_shadow_vld_nxt;
   logic              w_shadow_load;
`endif

   // Capacity lanes never leave the permutation core through this stage.
   assign w_unused = ^f_out[STATE_W-1:BUF_W];
   assign w_last   = (r_idx == last_idx(r_mode));

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_mode_nxt    = r_mode;
      w_ready_nxt   = r_out_ready;
      w_squeeze_nxt = 1'b0;
      w_buf_load    = 1'b0;
      w_buf_nxt     = f_out[BUF_W-1:0];
      w_out_load    = 1'b0;
`ifdef SQUEEZE_PREFETCH_EN
      w_shadow_vld_nxt = r_shadow_vld;
      w_shadow_load    = 1'b0;
`endif
      if (start_calc) begin
         w_state_nxt = SQ_WAIT_PERM;
         w_idx_nxt   = 5'd0;
         w_ready_nxt = 1'b0;
         w_mode_nxt  = mode;
`ifdef SQUEEZE_PREFETCH_EN
         w_shadow_vld_nxt = 1'b0;
`endif
      end else begin
         case (r_state)
            SQ_WAIT_PERM: begin
               if (stop) begin
                  w_state_nxt = SQ_DONE;
               end else if (f_out_ready) begin
                  w_buf_load  = 1'b1;
                  w_idx_nxt   = 5'd0;
                  w_ready_nxt = 1'b1;
                  w_out_load  = 1'b1;
                  w_state_nxt = SQ_DRAIN;
`ifdef SQUEEZE_PREFETCH_EN
                  w_squeeze_nxt = 1'b1;
`endif
               end
            end
            SQ_DRAIN: begin
               if (stop) begin
                  w_state_nxt = SQ_DONE;
                  w_ready_nxt = 1'b0;
`ifdef SQUEEZE_PREFETCH_EN
                  w_shadow_vld_nxt = 1'b0;
`endif
               end else if (gimme && w_last) begin
`ifdef SQUEEZE_PREFETCH_EN
                  // Zero-bubble hand-over: next block comes from the shadow,
                  // or straight from the permutation if it lands right now.
                  if (r_shadow_vld) begin
                     w_buf_nxt        = r_shadow;
                     w_buf_load       = 1'b1;
                     w_idx_nxt        = 5'd0;
                     w_out_load       = 1'b1;
                     w_shadow_vld_nxt = 1'b0;
                     w_squeeze_nxt    = 1'b1;
                  end else if (f_out_ready) begin
                     w_buf_load    = 1'b1;
                     w_idx_nxt     = 5'd0;
                     w_out_load    = 1'b1;
                     w_squeeze_nxt = 1'b1;
                  end else begin
                     w_ready_nxt = 1'b0;
                     w_state_nxt = SQ_WAIT_PERM;
                  end
`else
                  w_ready_nxt   = 1'b0;
                  w_squeeze_nxt = 1'b1;
                  w_state_nxt   = SQ_WAIT_PERM;
`endif
               end else begin
                  if (gimme) begin
                     w_idx_nxt  = r_idx + 5'd1;
                     w_out_load = 1'b1;
                  end
`ifdef SQUEEZE_PREFETCH_EN
                  if (f_out_ready && !r_shadow_vld) begin
                     w_shadow_load    = 1'b1;
                     w_shadow_vld_nxt = 1'b1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // The out register always looks at the buffer contents it will hold next.
   assign w_sel_buf = w_buf_load ? w_buf_nxt : r_buf;

   squeeze_word_sel u_word_sel (
      .i_buf  (w_sel_buf),
      .i_idx  (w_idx_nxt),
      .o_word (w_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= SQ_IDLE;
         r_idx       <= 5'd0;
         r_mode      <= 1'b0;
         r_out_ready <= 1'b0;
         r_squeeze   <= 1'b0;
         r_out       <= '0;
`ifdef SQUEEZE_PREFETCH_EN
         r_shadow_vld <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_mode      <= w_mode_nxt;
         r_out_ready <= w_ready_nxt;
         r_squeeze   <= w_squeeze_nxt;
         if (w_out_load) begin
            r_out <= w_word;
         end
`ifdef SQUEEZE_PREFETCH_EN
         r_shadow_vld <= w_shadow_vld_nxt;
`endif
      end
   end

   // Wide data storage carries no reset; validity is tracked by control.
   always_ff @(posedge clk) begin
      if (w_buf_load) begin
         r_buf <= w_buf_nxt;
      end
`ifdef SQUEEZE_PREFETCH_EN
      if (w_shadow_load) begin
         r_shadow <= f_out[BUF_W-1:0];
      end
`endif
   end

   assign out           = r_out;
   assign out_ready     = r_out_ready;
   assign out_buf_empty = ~r_out_ready;
   assign squeeze       = r_squeeze;

endmodule

// File: tb/tb_squeeze_buffer.sv
// Randomized self-checking bench for squeeze_buffer; expected words come from
// a lane-array/pop-count model of the rate buffer.
module tb_squeeze_buffer;

   logic          clk = 1'b0;
   logic          rst;
   logic          mode;
   logic          start_calc;
   logic [1599:0] f_out;
   logic          f_out_ready;
   logic          gimme;
   logic          stop;
   logic          squeeze;
   logic [63:0]   out;
   logic          out_ready;
   logic          out_buf_empty;

   int n_tests = 0;
   int n_fail  = 0;
   logic [63:0] lanes [21];

   squeeze_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .mode          (mode),
      .start_calc    (start_calc),
      .f_out         (f_out),
      .f_out_ready   (f_out_ready),
      .squeeze       (squeeze),
      .gimme         (gimme),
      .stop          (stop),
      .out           (out),
      .out_ready     (out_ready),
      .out_buf_empty (out_buf_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic make_state(input bit seq);
      logic [63:0] v;
      for (int i = 0; i < 25; i++) begin
         v = seq ? 64'(i) : {$urandom, $urandom};
         f_out[64*i +: 64] = v;
         if (i < 21) lanes[i] = v;
      end
   endtask

   task automatic do_start(input bit m);
      start_calc = 1'b1;
      mode       = m;
      step();
      start_calc = 1'b0;
      mode       = $urandom_range(1);
   endtask

   task automatic do_load(input bit seq);
      make_state(seq);
      f_out_ready = 1'b1;
      step();
      f_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      n_tests++;
      if (out !== 64'd0) begin n_fail++; $display("FAIL reset_out: got %h required %h", out, 64'd0); end
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b required 0", out_ready); end
      n_tests++;
      if (out_buf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b required 1", out_buf_empty); end
      n_tests++;
      if (squeeze !== 1'b0) begin n_fail++; $display("FAIL reset_squeeze: got %b required 0", squeeze); end
      rst = 1'b1;
      step();
      f_out_ready = 1'b1;
      gimme = 1'b1;
      make_state(1'b0);
      step();
      f_out_ready = 1'b0;
      gimme = 1'b0;
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ignores_fout: ready %b required 0", out_ready); end
   endtask

   task automatic test_reset_async();
      do_start(1'b0);
      do_load(1'b0);
      gimme = 1'b1;
      repeat (3) step();
      gimme = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_tests++;
      if (out_ready !== 1'b0 || out !== 64'd0 || out_buf_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: ready %b out %h empty %b required 0/0/1", out_ready, out, out_buf_empty);
      end
      @(negedge clk);
      rst = 1'b1;
      make_state(1'b0);
      f_out_ready = 1'b1;
      step();
      f_out_ready = 1'b0;
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: ready %b required 0", out_ready); end
   endtask

`ifndef SQUEEZE_PREFETCH_EN
   task automatic test_drain(input bit m, input bit seq, input int gap_pct, input bit violate);
      int rate, pos, sq_cnt;
      bit done, g;
      logic [63:0] exp_l [21];
      rate = m ? 17 : 21;
      do_start(m);
      do_load(seq);
      exp_l = lanes;
      n_tests++;
      if (out !== exp_l[0] || out_ready !== 1'b1 || out_buf_empty !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_first_word: out %h ready %b empty %b required %h/1/0", out, out_ready, out_buf_empty, exp_l[0]);
      end
      pos  = 0;
      done = 0;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         g = ($urandom_range(99) >= gap_pct);
         gimme = g;
         if (violate && $urandom_range(4) == 0) begin
            f_out = {$urandom, $urandom, $urandom, $urandom};
            f_out_ready = 1'b1;
         end
         step();
         gimme = 1'b0;
         f_out_ready = 1'b0;
         if (g) pos++;
         n_tests++;
         if (pos == rate) begin
            done = 1;
            if (squeeze !== 1'b1 || out_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL drain_end m%0d: squeeze %b ready %b required 1/0", m, squeeze, out_ready);
            end
         end else if (out !== exp_l[pos] || out_ready !== 1'b1 || squeeze !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_word m%0d[%0d]: out %h ready %b sq %b required %h/1/0", m, pos, out, out_ready, squeeze, exp_l[pos]);
         end
      end
      n_tests++;
      if (!done) begin n_fail++; $display("FAIL drain_timeout: popped %0d required %0d", pos, rate); end
      sq_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (squeeze === 1'b1) sq_cnt++;
      end
      n_tests++;
      if (sq_cnt != 0) begin n_fail++; $display("FAIL squeeze_single: extra pulses %0d required 0", sq_cnt); end
      n_tests++;
      if (out !== exp_l[rate-1] || out_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL out_hold: out %h ready %b required %h/0", out, out_ready, exp_l[rate-1]);
      end
   endtask

   task automatic test_stop();
      int sq_cnt;
      do_start(1'b0);
      do_load(1'b0);
      gimme = 1'b1;
      repeat (5) step();
      gimme = 1'b0;
      n_tests++;
      if (out !== lanes[5]) begin n_fail++; $display("FAIL stop_idx5: out %h required %h", out, lanes[5]); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      n_tests++;
      if (out_ready !== 1'b0 || out_buf_empty !== 1'b1 || squeeze !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_done: ready %b empty %b sq %b required 0/1/0", out_ready, out_buf_empty, squeeze);
      end
      sq_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (squeeze === 1'b1) sq_cnt++;
      end
      n_tests++;
      if (sq_cnt != 0) begin n_fail++; $display("FAIL stop_no_squeeze: pulses %0d required 0", sq_cnt); end
      do_load(1'b0);
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL done_ignores_fout: ready %b required 0", out_ready); end
   endtask

   task automatic test_last_stop();
      do_start(1'b1);
      do_load(1'b0);
      gimme = 1'b1;
      repeat (16) step();
      n_tests++;
      if (out !== lanes[16]) begin n_fail++; $display("FAIL last_stop_word: out %h required %h", out, lanes[16]); end
      stop = 1'b1;
      step();
      gimme = 1'b0;
      stop = 1'b0;
      n_tests++;
      if (out_ready !== 1'b0 || squeeze !== 1'b0) begin
         n_fail++;
         $display("FAIL last_stop: ready %b sq %b required 0/0", out_ready, squeeze);
      end
      step();
      n_tests++;
      if (squeeze !== 1'b0) begin n_fail++; $display("FAIL last_stop_late_sq: sq %b required 0", squeeze); end
   endtask

   task automatic test_restart();
      do_start(1'b0);
      do_load(1'b0);
      gimme = 1'b1;
      repeat (9) step();
      gimme = 1'b0;
      n_tests++;
      if (out !== lanes[9]) begin n_fail++; $display("FAIL restart_idx9: out %h required %h", out, lanes[9]); end
      do_start(1'b1);
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL restart_flush: ready %b required 0", out_ready); end
      do_load(1'b0);
      n_tests++;
      if (out !== lanes[0] || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_word0: out %h ready %b required %h/1", out, out_ready, lanes[0]);
      end
      gimme = 1'b1;
      repeat (16) step();
      n_tests++;
      if (out !== lanes[16] || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_mode1_last: out %h ready %b required %h/1", out, out_ready, lanes[16]);
      end
      step();
      gimme = 1'b0;
      n_tests++;
      if (squeeze !== 1'b1 || out_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_mode1_end: sq %b ready %b required 1/0", squeeze, out_ready);
      end
   endtask

   task automatic test_start_vs_fout();
      do_start(1'b0);
      do_load(1'b0);
      make_state(1'b0);
      start_calc  = 1'b1;
      mode        = 1'b0;
      f_out_ready = 1'b1;
      step();
      start_calc  = 1'b0;
      f_out_ready = 1'b0;
      n_tests++;
      if (out_ready !== 1'b0) begin n_fail++; $display("FAIL flush_wins: ready %b required 0", out_ready); end
      do_load(1'b0);
      n_tests++;
      if (out !== lanes[0] || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_then_load: out %h ready %b required %h/1", out, out_ready, lanes[0]);
      end
   endtask
`else
   task automatic test_prefetch();
      logic [63:0] stream [42];
      do_start(1'b0);
      do_load(1'b0);
      for (int i = 0; i < 21; i++) stream[i] = lanes[i];
      n_tests++;
      if (squeeze !== 1'b1 || out !== stream[0] || out_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL pf_load: sq %b out %h ready %b required 1/%h/1", squeeze, out, out_ready, stream[0]);
      end
      gimme = 1'b1;
      for (int k = 1; k < 42; k++) begin
         if (k == 6) begin
            make_state(1'b0);
            for (int i = 0; i < 21; i++) stream[21+i] = lanes[i];
            f_out_ready = 1'b1;
         end
         step();
         f_out_ready = 1'b0;
         n_tests++;
         if (out !== stream[k] || out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pf_stream[%0d]: out %h ready %b required %h/1", k, out, out_ready, stream[k]);
         end
      end
      gimme = 1'b0;
   endtask
`endif

   initial begin
      rst         = 1'b0;
      mode        = 1'b0;
      start_calc  = 1'b0;
      f_out       = '0;
      f_out_ready = 1'b0;
      gimme       = 1'b0;
      stop        = 1'b0;
      test_reset();
`ifndef SQUEEZE_PREFETCH_EN
      test_drain(1'b0, 1'b1, 0, 1'b0);
      test_drain(1'b1, 1'b1, 0, 1'b0);
      test_drain(1'b0, 1'b0, 40, 1'b1);
      test_drain(1'b1, 1'b0, 30, 1'b1);
      test_stop();
      test_last_stop();
      test_restart();
      test_start_vs_fout();
`else
      test_prefetch();
`endif
      test_reset_async();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
